// File: rtl/lif_timestep_sequencer_if.sv
// Bundle of the handshake, SRAM and event signals of the LIF timestep sequencer.
// The sequencer connects through the master modport. The environment (input
// current source, membrane SRAM, spike consumer) connects through slave.
// With LIF_SPIKE_COUNT_EN defined, the bundle also carries spike_count.
interface lif_timestep_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                    start;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_current;
  logic                    in_ready;
  logic                    mem_we;
  logic [AW-1:0]           mem_addr;
  logic signed [WIDTH-1:0] mem_wdata;
  logic signed [WIDTH-1:0] mem_rdata;
  logic                    spike_valid;
  logic [AW-1:0]           spike_addr;
  logic                    busy;
  logic                    done;
`ifdef LIF_SPIKE_COUNT_EN
  logic [CW-1:0]           spike_count;

  modport master (
    input  start, in_valid, in_current, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output spike_valid, spike_addr, busy, done, spike_count
  );

  modport slave (
    output start, in_valid, in_current, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  spike_valid, spike_addr, busy, done, spike_count
  );
`else
  modport master (
    input  start, in_valid, in_current, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output spike_valid, spike_addr, busy, done
  );

  modport slave (
    output start, in_valid, in_current, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  spike_valid, spike_addr, busy, done
  );
`endif
endinterface

// File: rtl/lif_timestep_sequencer.sv
// LIF timestep sequencer. On each start, it sweeps neurons 0..DEPTH-1 through
// READ -> CALC -> WRITE. For each neuron it applies v - (v >>> LEAK_SHIFT) + I
// with saturation, thresholds the result, writes it back to the membrane SRAM,
// and flags a spike.
// Optional: define LIF_SPIKE_COUNT_EN to add a per-sweep spike_count output.
module lif_timestep_sequencer #(
  parameter int                      WIDTH           = 32,
  parameter int                      DEPTH           = 256,
  parameter logic signed [WIDTH-1:0] THRESHOLD       = 1000,
  parameter int                      LEAK_SHIFT      = 4,
  parameter logic signed [WIDTH-1:0] RESET_POTENTIAL = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  lif_timestep_sequencer_if.master      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 2;
  localparam logic [AW-1:0]           LAST = AW'(DEPTH - 1);
  localparam logic signed [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                  state_q;
  logic [AW-1:0]           cnt_q;
  logic                    in_ready_q;
  logic                    mem_we_q;
  logic [AW-1:0]           mem_addr_q;
  logic signed [WIDTH-1:0] mem_wdata_q;
  logic                    spike_valid_q;
  logic [AW-1:0]           spike_addr_q;
  logic                    busy_q;
  logic                    done_q;
`ifdef LIF_SPIKE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0]           spike_cnt_q;
`endif

  logic signed [WIDTH-1:0] v_new_d;
  logic                    spike_d;

  // Membrane update in WIDTH+2 bits. The leak uses an arithmetic shift, so
  // negative potentials decay toward zero from below.
  function automatic logic signed [EW-1:0] leak_update(
    input logic signed [WIDTH-1:0] v,
    input logic signed [WIDTH-1:0] cur
  );
    logic signed [EW-1:0] ve;
    logic signed [EW-1:0] le;
    logic signed [EW-1:0] ce;
    ve = EW'(v);
    le = EW'(v >>> LEAK_SHIFT);
    ce = EW'(cur);
    return ve - le + ce;
  endfunction

  // Clamp to the signed WIDTH range. The value fits only when the top
  // three bits all equal the sign bit.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [EW-1:0] x);
    if (x[EW-1:WIDTH-1] == {3{x[EW-1]}}) begin
      return x[WIDTH-1:0];
    end else if (x[EW-1]) begin
      return VMIN;
    end else begin
      return VMAX;
    end
  endfunction

  // New potential and spike decision, from the registered SRAM word and the offered current
  always_comb begin
    v_new_d = sat_w(leak_update(bus.mem_rdata, bus.in_current));
    spike_d = (v_new_d >= THRESHOLD);
  end

  // Sweep FSM. Every output is a register that is loaded on the transition into the state that shows it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      spike_valid_q <= 1'b0;
      spike_addr_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef LIF_SPIKE_COUNT_EN
      spike_cnt_q   <= '0;
`endif
    end else begin
      done_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_READ;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            busy_q     <= 1'b1;
`ifdef LIF_SPIKE_COUNT_EN
            spike_cnt_q <= '0;
`endif
          end
        end
        // The SRAM captures memory[mem_addr] at the end of READ; its word is valid throughout CALC
        S_READ: begin
          state_q    <= S_CALC;
          in_ready_q <= 1'b1;
        end
        S_CALC: begin
          if (bus.in_valid && in_ready_q) begin
            state_q       <= S_WRITE;
            in_ready_q    <= 1'b0;
            mem_we_q      <= 1'b1;
            mem_wdata_q   <= spike_d ? RESET_POTENTIAL : v_new_d;
            spike_valid_q <= spike_d;
            spike_addr_q  <= cnt_q;
          end
        end
        S_WRITE: begin
          mem_we_q <= 1'b0;
`ifdef LIF_SPIKE_COUNT_EN
          if (spike_valid_q) begin
            spike_cnt_q <= spike_cnt_q + 1'b1;
          end
`endif
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_READ;
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_addr  = spike_addr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
`ifdef LIF_SPIKE_COUNT_EN
  assign bus.spike_count = spike_cnt_q;
`endif

endmodule

// File: tb/tb_lif_timestep_sequencer.sv
// Directed bench for lif_timestep_sequencer. Two instances (DEPTH=4, LEAK_SHIFT=1):
// instance A uses THRESHOLD=100, and instance B uses THRESHOLD=2^31-1 for the saturation cases.
// Each instance has a behavioural registered-read SRAM. Currents come from a per-address table.
module tb_lif_timestep_sequencer;
  localparam int VMAX = 32'sh7fffffff;
  localparam int VMIN = 32'sh80000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lif_timestep_sequencer_if #(.WIDTH(32), .DEPTH(4)) ia ();
  lif_timestep_sequencer_if #(.WIDTH(32), .DEPTH(4)) ib ();

  lif_timestep_sequencer #(.WIDTH(32), .DEPTH(4), .THRESHOLD(32'sd100),
                           .LEAK_SHIFT(1), .RESET_POTENTIAL(32'sd0))
    dut_a (.clk(clk), .reset(reset), .bus(ia));

  lif_timestep_sequencer #(.WIDTH(32), .DEPTH(4), .THRESHOLD(32'sh7fffffff),
                           .LEAK_SHIFT(1), .RESET_POTENTIAL(32'sd0))
    dut_b (.clk(clk), .reset(reset), .bus(ib));

  logic signed [31:0] mem_a [0:3];
  logic signed [31:0] mem_b [0:3];
  logic signed [31:0] cur_a [0:3];
  logic signed [31:0] cur_b [0:3];
  logic               pre_we, pre_sel;
  logic [1:0]         pre_addr;
  logic signed [31:0] pre_data;
  logic               mon_clr;
  logic [3:0]         spk_a, spk_b;

  assign ia.in_current = cur_a[ia.mem_addr];
  assign ib.in_current = cur_b[ib.mem_addr];

  // Membrane SRAMs with a registered read word and a bench preload port
  always @(posedge clk) begin
    if (pre_we && !pre_sel) mem_a[pre_addr] <= pre_data;
    else if (ia.mem_we)     mem_a[ia.mem_addr] <= ia.mem_wdata;
    ia.mem_rdata <= mem_a[ia.mem_addr];
    if (pre_we && pre_sel)  mem_b[pre_addr] <= pre_data;
    else if (ib.mem_we)     mem_b[ib.mem_addr] <= ib.mem_wdata;
    ib.mem_rdata <= mem_b[ib.mem_addr];
  end

  // Spike address collectors
  always @(posedge clk) begin
    if (mon_clr) begin
      spk_a <= '0;
      spk_b <= '0;
    end else begin
      if (ia.spike_valid) spk_a[ia.spike_addr] <= 1'b1;
      if (ib.spike_valid) spk_b[ib.spike_addr] <= 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [1:0] addr, input logic signed [31:0] d);
    pre_sel = sel; pre_addr = addr; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic set_cur_a(input int c0, input int c1, input int c2, input int c3);
    cur_a[0] = c0; cur_a[1] = c1; cur_a[2] = c2; cur_a[3] = c3;
  endtask

  task automatic check_mem_a(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
    check({tag, "_m0"}, mem_a[0], e0);
    check({tag, "_m1"}, mem_a[1], e1);
    check({tag, "_m2"}, mem_a[2], e2);
    check({tag, "_m3"}, mem_a[3], e3);
  endtask

  // One sweep on instance A. Cycle 1 is the first cycle after the start edge.
  // Optionally stalls CALC of neuron 1, or re-pulses start while busy and during DONE.
  task automatic sweep_a(input int stall_n, input bit poke, output int cyc_done, output int n_done);
    int cyc;
    int stall_left;
    cyc_done = 0; n_done = 0; stall_left = stall_n;
    ia.in_valid = 1'b1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      if (cyc_done != 0 && cyc > cyc_done + 2) break;
      ia.start = 1'b0;
      if (ia.in_ready && ia.mem_addr == 2'd1 && stall_left > 0) begin
        ia.in_valid = 1'b0;
        stall_left--;
        check("stall_we", ia.mem_we, 0);
        check("stall_spike", ia.spike_valid, 0);
        check("stall_busy", ia.busy, 1);
      end else begin
        ia.in_valid = 1'b1;
      end
      if (poke && (cyc == 3 || cyc == 7)) ia.start = 1'b1;
      if (ia.done) begin
        n_done++;
        if (cyc_done == 0) cyc_done = cyc;
        if (poke) ia.start = 1'b1;
      end
      if (cyc_done != 0 && cyc == cyc_done + 1) check("idle_after_done", ia.busy, 0);
      tick();
      cyc++;
    end
    ia.start = 1'b0;
  endtask

  initial begin
    int cd;
    int nd;
    int k;
    reset = 1'b1;
    ia.start = 1'b0; ia.in_valid = 1'b0;
    ib.start = 1'b0; ib.in_valid = 1'b1;
    pre_we = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
    mon_clr = 1'b1;
    set_cur_a(0, 0, 0, 0);
    cur_b[0] = 0; cur_b[1] = VMAX; cur_b[2] = VMIN; cur_b[3] = 0;
    for (int i = 0; i < 4; i++) preload(1'b0, 2'(i), 32'sd0);
    preload(1'b1, 2'd0, -32'sd8);
    preload(1'b1, 2'd1, VMAX);
    preload(1'b1, 2'd2, VMIN);
    preload(1'b1, 2'd3, 32'sd5);

    // Reset state
    check("rst_busy", ia.busy, 0);
    check("rst_done", ia.done, 0);
    check("rst_we", ia.mem_we, 0);
    check("rst_ready", ia.in_ready, 0);
    check("rst_spike", ia.spike_valid, 0);
    check("rst_addr", ia.mem_addr, 0);
`ifdef LIF_SPIKE_COUNT_EN
    check("rst_scount", ia.spike_count, 0);
`endif
    reset = 1'b0;
    tick();
    mon_clr = 1'b0;
    tick();

    // Sweep 1: zeroed SRAM, currents of 50
    set_cur_a(50, 50, 50, 50);
    sweep_a(0, 1'b0, cd, nd);
    check("s1_cycles", cd, 13);
    check("s1_ndone", nd, 1);
    check_mem_a("s1", 50, 50, 50, 50);
    check("s1_spikes", spk_a, 4'b0000);

    // Sweep 2: 50-25+80=105 spikes, 50-25+10=35 does not
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    set_cur_a(80, 10, 80, 10);
    sweep_a(0, 1'b0, cd, nd);
    check("s2_cycles", cd, 13);
    check_mem_a("s2", 0, 35, 0, 35);
    check("s2_spikes", spk_a, 4'b0101);
`ifdef LIF_SPIKE_COUNT_EN
    check("s2_scount", ia.spike_count, 2);
`endif

    // Sweep 3: 3-cycle stall on neuron 1; 35-17+0=18
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    set_cur_a(0, 0, 0, 0);
    sweep_a(3, 1'b0, cd, nd);
    check("s3_cycles", cd, 16);
    check("s3_ndone", nd, 1);
    check_mem_a("s3", 0, 18, 0, 18);
    check("s3_spikes", spk_a, 4'b0000);

    // Sweep 4: start pulsed while busy and during DONE; 18-9+10=19
    set_cur_a(10, 10, 10, 10);
    sweep_a(0, 1'b1, cd, nd);
    check("s4_cycles", cd, 13);
    check("s4_ndone", nd, 1);
    check_mem_a("s4", 10, 19, 10, 19);

    // Sweep 5: reset during the WRITE of neuron 2
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    set_cur_a(200, 200, 200, 200);
    ia.in_valid = 1'b1;
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    k = 0;
    while (k < 40 && !(ia.mem_we && ia.mem_addr == 2'd2)) begin
      tick();
      k++;
    end
    check("s5_reached_w2", ia.mem_addr, 2);
    check("s5_reached_we", ia.mem_we, 1);
    reset = 1'b1;
    #1;
    check("s5_rst_we", ia.mem_we, 0);
    check("s5_rst_addr", ia.mem_addr, 0);
    check("s5_rst_wdata", ia.mem_wdata, 0);
    check("s5_rst_spike", ia.spike_valid, 0);
    check("s5_rst_saddr", ia.spike_addr, 0);
    check("s5_rst_busy", ia.busy, 0);
    check("s5_rst_done", ia.done, 0);
    check("s5_rst_ready", ia.in_ready, 0);
`ifdef LIF_SPIKE_COUNT_EN
    check("s5_rst_scount", ia.spike_count, 0);
`endif
    tick();
    check_mem_a("s5", 0, 0, 10, 19);
    check("s5_spikes", spk_a, 4'b0011);
    reset = 1'b0;
    tick();
    check("s5_idle", ia.busy, 0);

    // Sweep 6: full sweep after the abort; 10-5+1=6, 19-9+1=11
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    set_cur_a(1, 1, 1, 1);
    sweep_a(0, 1'b0, cd, nd);
    check("s6_cycles", cd, 13);
    check("s6_ndone", nd, 1);
    check_mem_a("s6", 1, 1, 6, 11);
    check("s6_spikes", spk_a, 4'b0000);

    // Instance B: arithmetic leak on -8, positive and negative saturation
    ib.start = 1'b1;
    tick();
    ib.start = 1'b0;
    k = 0;
    while (k < 40 && !ib.done) begin
      tick();
      k++;
    end
    check("b_done", ib.done, 1);
    check("b_cycles", k + 1, 13);
    check("b_m0_neg_leak", mem_b[0], -4);
    check("b_m1_sat_spike", mem_b[1], 0);
    check("b_m2_sat_min", mem_b[2], VMIN);
    check("b_m3", mem_b[3], 3);
    check("b_spikes", spk_b, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lif_timestep_sequencer.md
Name: lif_timestep_sequencer

Overview:
Per-timestep update engine for the leaky integrate-and-fire neuron array. Membrane potentials live in the single-port membrane SRAM.
- On each start pulse, walks every neuron address 0..DEPTH-1.
- For each neuron: reads the potential, applies leak and input current, thresholds, writes back, and emits a spike event.
- Sits directly upstream of the SRAM and drives its write_enable/addr/write_word; consumes its registered read word.

Parameters:
WIDTH, 32, signed potential/current width (matches SRAM WIDTH)
DEPTH, 256, number of neurons (matches SRAM DEPTH)
THRESHOLD, 1000, signed firing threshold; spike when v_new >= THRESHOLD
LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT (arithmetic)
RESET_POTENTIAL, 0, value written back after a spike

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin one timestep sweep; ignored unless IDLE
in_valid  in  1  input current valid
in_current  in  WIDTH signed  synaptic current for current neuron, in address order
in_ready  out  1  sequencer accepts in_current this cycle
mem_we  out  1  SRAM write_enable
mem_addr  out  $clog2(DEPTH)  SRAM addr
mem_wdata  out  WIDTH signed  SRAM write_word
mem_rdata  in  WIDTH signed  SRAM registered read word
spike_valid  out  1  one-cycle spike pulse
spike_addr  out  $clog2(DEPTH)  index of spiking neuron
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset value of all outputs is 0, and the state is IDLE. Asynchronous reset mid-sweep aborts immediately: no partial write, no spike, no done. The SRAM is not reset by this block.
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- IDLE -> READ on start. The address counter is cleared to 0.
- READ: mem_addr = counter, mem_we = 0. Always -> CALC. The SRAM registers memory[addr] at this edge, so mem_rdata is valid throughout CALC (1-cycle read latency).
- CALC:
  - mem_addr held, mem_we = 0, in_ready = 1.
  - Stays in CALC while in_valid = 0 (stall, no side effects).
  - On in_valid & in_ready: v_new is computed and registered, then -> WRITE.
- Arithmetic:
  - v_new = v - (v >>> LEAK_SHIFT) + in_current.
  - Computed in WIDTH+2 bits, saturated to the signed WIDTH range: max 2^(WIDTH-1)-1, min -2^(WIDTH-1).
- WRITE:
  - mem_we = 1, mem_addr = counter.
  - If v_new >= THRESHOLD (signed compare): mem_wdata = RESET_POTENTIAL, spike_valid = 1, spike_addr = counter. Otherwise mem_wdata = v_new, spike_valid = 0.
  - If counter == DEPTH-1 -> DONE. Otherwise counter++ and -> READ.
- DONE: done = 1 for one cycle, -> IDLE.
- Cost is 3 cycles per neuron with no stalls. Sweep from the start edge to the done pulse is 3*DEPTH+1 cycles.
- in_ready is never high outside CALC. start while busy is ignored. start in the same cycle as DONE is ignored.
- The counter has no wrap-around within a sweep; it terminates at DEPTH-1.

Optional Feature:
Macro LIF_SPIKE_COUNT_EN.
- Defined: adds output spike_count, width $clog2(DEPTH+1), unsigned.
  - Cleared to 0 on reset and on the accepted start.
  - Increments in each WRITE cycle with spike_valid.
  - Holds its value after DONE until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- DEPTH=4, THRESHOLD=100, LEAK_SHIFT=1, SRAM zeroed, start with currents 50,50,50,50 always valid -> memory {50,50,50,50}, no spike_valid, done exactly 13 cycles after start.
- Second sweep, currents 80,10,80,10 -> v_new 105,35,105,35. Spikes at addr 0 and 2, memory {0,35,0,35}; spike_count=2 with LIF_SPIKE_COUNT_EN.
- Neuron preloaded -8, current 0 -> written -4 (arithmetic leak), no spike; preloaded 2^31-1 with current 2^31-1, THRESHOLD=2^31-1 -> saturates, spike, writes 0.
- in_valid held low 3 cycles in CALC of neuron 1 -> in_ready high, mem_we low, FSM stays in CALC; sweep length extended by exactly 3 cycles, results unchanged.
- start pulsed while busy -> ignored, single done. Reset asserted during a WRITE of neuron 2 -> all outputs 0 at once, state IDLE; a new start redoes a full sweep correctly.
